// File: rtl/hash_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hash_pkg
//  Description : Constants and types shared by the BLAKE work scheduler and
//                the hashcore (pipeline latency, bus widths, state encoding).
//  Revision    : 1.0 - initial release
// ============================================================================
package hash_pkg;

   // Core pipeline depth; hashcore subtracts the same value for its nonce fixup
   localparam int HASH_LATENCY = 130;

   localparam int MIDSTATE_W = 256;
   localparam int DATA_W     = 96;
   localparam int NONCE_W    = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } sched_state_t;

endpackage : hash_pkg
`default_nettype wire

// File: rtl/hash_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : hash_result_fifo
//  Description : Small synchronous FIFO for golden-nonce results. A push while
//                full is accepted when a pop happens in the same cycle.
//                DEPTH must be a power of two, at least 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module hash_result_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign count   = count_q;
   // Head reads as zero when empty so the output never shows stale storage
   assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

   // Pointer and occupancy update; pointers wrap naturally at DEPTH
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state registers, cleared by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule : hash_result_fifo
`default_nettype wire

// File: rtl/hash_work_sched.sv
`default_nettype none
// ============================================================================
//  Module      : hash_work_sched
//  Description : Sequences one BLAKE hashcore: accepts a job, issues one nonce
//                per cycle over the job range, qualifies returning golden
//                nonces against pipeline blanking and the job range, and
//                queues qualified hits for the host side.
//  Revision    : 1.0 - initial release
// ============================================================================
module hash_work_sched
   import hash_pkg::*;
#(
   parameter int LATENCY    = HASH_LATENCY,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  hash_clk,
   input  logic                  reset_n,
   input  logic                  job_valid,
   output logic                  job_ready,
   input  logic [MIDSTATE_W-1:0] job_midstate,
   input  logic [DATA_W-1:0]     job_data,
   input  logic [NONCE_W-1:0]    job_nonce_start,
   input  logic [NONCE_W-1:0]    job_nonce_end,
   output logic [MIDSTATE_W-1:0] core_midstate,
   output logic [DATA_W-1:0]     core_data,
   output logic [NONCE_W-1:0]    core_nonce,
   input  logic                  core_match,
   input  logic [NONCE_W-1:0]    core_golden_nonce,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [NONCE_W-1:0]    res_nonce,
   output logic                  busy,
   output logic                  job_done,
   output logic                  overflow
);

   localparam int               CNT_W      = $clog2(LATENCY + 2);
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(LATENCY + 1);
   localparam int               FCNT_W     = $clog2(FIFO_DEPTH) + 1;

   sched_state_t          state_q, state_d;
   logic [MIDSTATE_W-1:0] core_midstate_q, core_midstate_d;
   logic [DATA_W-1:0]     core_data_q, core_data_d;
   logic [NONCE_W-1:0]    core_nonce_q, core_nonce_d;
   logic [NONCE_W-1:0]    range_start_q, range_start_d;
   logic [NONCE_W-1:0]    range_end_q, range_end_d;
   logic [CNT_W-1:0]      blank_q, blank_d;
   logic [CNT_W-1:0]      drain_q, drain_d;
   logic                  job_done_q, job_done_d;
   logic                  overflow_q, overflow_d;

   logic                  accept;
   logic                  run_last;
   logic                  drain_last;
   logic                  hit_ok;
   logic                  fifo_pop;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [FCNT_W-1:0]     fifo_count;

   // The scheduler always takes a new job; an accept preempts any current one
   assign accept = job_valid;

   // ">=" also covers start > end, which collapses to a single nonce
   assign run_last   = (core_nonce_q >= range_end_q);
   assign drain_last = (drain_q <= CNT_W'(1));

   // Hits count only after the blanking window, inside the job range, with a job live
   assign hit_ok = core_match
                && (blank_q == '0)
                && (core_golden_nonce >= range_start_q)
                && (core_golden_nonce <= range_end_q)
                && (state_q != IDLE);

   assign fifo_pop = res_ready && !fifo_empty;

   // State register and datapath registers
   always_ff @(posedge hash_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= IDLE;
         core_midstate_q <= '0;
         core_data_q     <= '0;
         core_nonce_q    <= '0;
         range_start_q   <= '0;
         range_end_q     <= '0;
         blank_q         <= '0;
         drain_q         <= '0;
         job_done_q      <= 1'b0;
         overflow_q      <= 1'b0;
      end else begin
         state_q         <= state_d;
         core_midstate_q <= core_midstate_d;
         core_data_q     <= core_data_d;
         core_nonce_q    <= core_nonce_d;
         range_start_q   <= range_start_d;
         range_end_q     <= range_end_d;
         blank_q         <= blank_d;
         drain_q         <= drain_d;
         job_done_q      <= job_done_d;
         overflow_q      <= overflow_d;
      end
   end

   // Next-state: accept wins, RUN ends on the last nonce, DRAIN ends when the counter empties
   always_comb begin
      state_d = state_q;
      if (accept) begin
         state_d = RUN;
      end else begin
         case (state_q)
            RUN:     if (run_last)   state_d = DRAIN;
            DRAIN:   if (drain_last) state_d = IDLE;
            default: state_d = state_q;
         endcase
      end
   end

   // Datapath: job load, nonce walk, blanking and drain counters, done pulse
   always_comb begin
      core_midstate_d = core_midstate_q;
      core_data_d     = core_data_q;
      core_nonce_d    = core_nonce_q;
      range_start_d   = range_start_q;
      range_end_d     = range_end_q;
      drain_d         = drain_q;
      job_done_d      = 1'b0;
      blank_d         = (blank_q != '0) ? (blank_q - CNT_W'(1)) : blank_q;
      overflow_d      = overflow_q | (hit_ok && fifo_full && !fifo_pop);

      if (accept) begin
         core_midstate_d = job_midstate;
         core_data_d     = job_data;
         core_nonce_d    = job_nonce_start;
         range_start_d   = job_nonce_start;
         range_end_d     = job_nonce_end;
         blank_d         = CNT_RELOAD;
         drain_d         = '0;
      end else begin
         case (state_q)
            RUN: begin
               if (run_last) drain_d      = CNT_RELOAD;
               else          core_nonce_d = core_nonce_q + NONCE_W'(1);
            end
            DRAIN: begin
               if (drain_q != '0) drain_d = drain_q - CNT_W'(1);
               if (drain_last)    job_done_d = 1'b1;
            end
            default: drain_d = drain_q;
         endcase
      end
   end

   // Outputs derived from state and registers
   always_comb begin
      job_ready     = 1'b1;
      busy          = (state_q != IDLE);
      core_midstate = core_midstate_q;
      core_data     = core_data_q;
      core_nonce    = core_nonce_q;
      job_done      = job_done_q;
      overflow      = overflow_q;
      res_valid     = (fifo_count != '0);
   end

   hash_result_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (NONCE_W)
   ) u_result_fifo (
      .clk       (hash_clk),
      .rst_n     (reset_n),
      .push      (hit_ok),
      .push_data (core_golden_nonce),
      .pop       (fifo_pop),
      .pop_data  (res_nonce),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

endmodule : hash_work_sched
`default_nettype wire
